// File: rtl/relu_array_pipe.sv
// Two-stage valid/accept ReLU pipeline over NUM_NODES x NUM_FEAT signed elements with frame sparsity.
// Define RELU_LEAKY_EN to scale negative inputs by an arithmetic right shift instead of zeroing them.
module relu_array_pipe #(
  parameter int unsigned DATA_W        = 5,
  parameter int unsigned NUM_NODES     = 4,
  parameter int unsigned NUM_FEAT      = 4,
  parameter int unsigned VEC_PER_FRAME = 4,
  parameter int unsigned LEAKY_SHIFT   = 3,
  localparam int unsigned NUM_EL = NUM_NODES * NUM_FEAT,
  localparam int unsigned VEC_W  = NUM_EL * DATA_W,
  localparam int unsigned ZCNT_W = $clog2(NUM_EL * VEC_PER_FRAME + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_ready,
  output logic              in_accept,
  input  logic [VEC_W-1:0]  in_data,
  output logic              relu_ready,
  input  logic              out_accept,
  output logic [VEC_W-1:0]  out_data,
  output logic              frame_done,
  output logic [ZCNT_W-1:0] zero_cnt
);

  localparam int unsigned CNT_W  = $clog2(NUM_EL + 1);
  localparam int unsigned FCNT_W = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;

  logic              v0_q, v1_q;
  logic [VEC_W-1:0]  d0_q, d1_q, relu_d;
  logic [CNT_W-1:0]  vzero_d, vzero_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [ZCNT_W-1:0] acc_q, zero_cnt_q, acc_sum;
  logic              frame_done_q;
  logic              adv0, adv1, in_xfer, out_xfer, last_xfer;

  assign adv1      = !v1_q || out_accept;
  assign adv0      = !v0_q || adv1;
  assign in_accept = adv0;
  assign in_xfer   = in_ready && adv0;
  assign out_xfer  = v1_q && out_accept;
  assign last_xfer = out_xfer && (fcnt_q == FCNT_W'(VEC_PER_FRAME - 1));
  assign acc_sum   = acc_q + ZCNT_W'(vzero_q);

  assign relu_ready = v1_q;
  assign out_data   = d1_q;
  assign frame_done = frame_done_q;
  assign zero_cnt   = zero_cnt_q;

`ifndef RELU_LEAKY_EN
  logic unused_leaky;
  assign unused_leaky = ^LEAKY_SHIFT;
`endif

  // Element-wise ReLU on stage 0 contents; count outputs that end up exactly zero.
  always_comb begin
    logic signed [DATA_W-1:0] elem;
    logic signed [DATA_W-1:0] res;
    elem    = '0;
    res     = '0;
    relu_d  = '0;
    vzero_d = '0;
    for (int i = 0; i < int'(NUM_EL); i++) begin
      elem = $signed(d0_q[i*DATA_W +: DATA_W]);
      if (elem[DATA_W-1]) begin
`ifdef RELU_LEAKY_EN
        res = elem >>> LEAKY_SHIFT;
`else
        res = '0;
`endif
      end else begin
        res = elem;
      end
      relu_d[i*DATA_W +: DATA_W] = res;
      if (res == '0) vzero_d = vzero_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q    <= 1'b0;
      d0_q    <= '0;
      v1_q    <= 1'b0;
      d1_q    <= '0;
      vzero_q <= '0;
    end else begin
      if (adv0) v0_q <= in_ready;
      if (in_xfer) d0_q <= in_data;
      if (adv1) v1_q <= v0_q;
      if (adv1 && v0_q) begin
        d1_q    <= relu_d;
        vzero_q <= vzero_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q       <= '0;
      acc_q        <= '0;
      zero_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_xfer;
      if (last_xfer) begin
        fcnt_q     <= '0;
        acc_q      <= '0;
        zero_cnt_q <= acc_sum;
      end else if (out_xfer) begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
        acc_q  <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_relu_array_pipe.sv
// Directed self-checking bench for relu_array_pipe at default parameters (5-bit, 4x4, 4 per frame).
module tb_relu_array_pipe;

  localparam int unsigned VW = 80;

  logic          clk, rst, in_ready, in_accept, relu_ready, out_accept, frame_done;
  logic [VW-1:0] in_data, out_data;
  logic [6:0]    zero_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  relu_array_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_ready   (in_ready),
    .in_accept  (in_accept),
    .in_data    (in_data),
    .relu_ready (relu_ready),
    .out_accept (out_accept),
    .out_data   (out_data),
    .frame_done (frame_done),
    .zero_cnt   (zero_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_ready   = 1'b0;
    out_accept = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  function automatic logic [VW-1:0] fill(input logic [4:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*5 +: 5] = v;
    return r;
  endfunction

  logic [VW-1:0] s_in, s_exp, b_in;
  int exp_id, next_id;

  initial begin
    rst        = 1'b1;
    in_ready   = 1'b0;
    out_accept = 1'b0;
    in_data    = '0;
    #1;
    check("rst_relu_ready", relu_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_zero_cnt", zero_cnt, 0);
    do_reset();
    check("rel_in_accept", in_accept, 1);

    // Basic: per node {-3,0,7,15} -> {0,0,7,15}
    in_data    = 80'h79C1D_79C1D_79C1D_79C1D;
    in_ready   = 1'b1;
    out_accept = 1'b1;
    tick();
    in_ready = 1'b0;
    check("basic_lat1", relu_ready, 0);
    tick();
    check("basic_valid", relu_ready, 1);
    check("basic_data", out_data, 80'h79C00_79C00_79C00_79C00);
    tick();
    check("basic_drain", relu_ready, 0);

    // Streaming: elements -1..-8, 0, 1..7 -> 9 zeros per vector, 36 per frame
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_in[i*5 +: 5]  = (i < 8) ? 5'(-(i + 1)) : 5'(i - 8);
      s_exp[i*5 +: 5] = (i <= 8) ? 5'd0 : 5'(i - 8);
    end
    in_data    = s_in;
    in_ready   = 1'b1;
    out_accept = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) in_ready = 1'b0;
      check("stream_valid", relu_ready, (k >= 2 && k <= 5));
      check("stream_fd", frame_done, (k == 6));
      if (relu_ready) check("stream_data", out_data, s_exp);
    end
    check("stream_zero_cnt", zero_cnt, 36);

    // Async reset mid-stream
    in_ready   = 1'b1;
    out_accept = 1'b0;
    tick();
    in_ready = 1'b0;
    tick();
    check("pre_rst_valid", relu_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_relu_ready", relu_ready, 0);
    check("arst_zero_cnt", zero_cnt, 0);
    check("arst_frame_done", frame_done, 0);
    check("arst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_in_accept", in_accept, 1);
    tick();

    // Backpressure: 2 fill cycles + 5 stalled cycles, then drain 6 vectors in order
    exp_id  = 1;
    next_id = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_accept = (cyc >= 7);
      in_ready   = (next_id <= 6);
      in_data    = fill(5'(next_id));
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        check("bp_in_accept", in_accept, 0);
        check("bp_hold", out_data, fill(5'd1));
      end
      if (relu_ready && out_accept) begin
        check("bp_order", out_data, fill(5'(exp_id)));
        exp_id++;
      end
      if (in_ready && in_accept) next_id++;
      tick();
    end
    check("bp_all_out", exp_id, 7);
    check("bp_all_in", next_id, 7);
    check("bp_empty", relu_ready, 0);

    // Boundary: -16, +15, -1, -8
    do_reset();
    b_in = '0;
    b_in[4:0]   = 5'h10;
    b_in[9:5]   = 5'd15;
    b_in[14:10] = 5'h1F;
    b_in[19:15] = 5'h18;
    in_data    = b_in;
    in_ready   = 1'b1;
    out_accept = 1'b1;
    tick();
    in_ready = 1'b0;
    tick();
    check("bnd_valid", relu_ready, 1);
`ifdef RELU_LEAKY_EN
    check("bnd_min_neg", out_data[4:0], 5'h1E);
    check("bnd_neg1", out_data[14:10], 5'h1F);
    check("bnd_neg8", out_data[19:15], 5'h1F);
`else
    check("bnd_min_neg", out_data[4:0], 5'h00);
    check("bnd_neg1", out_data[14:10], 5'h00);
    check("bnd_neg8", out_data[19:15], 5'h00);
`endif
    check("bnd_max_pos", out_data[9:5], 5'd15);
    tick();

    // Frame wrap: 9 all-zero vectors -> pulses after transfers 4 and 8, zero_cnt 64
    do_reset();
    in_data    = fill(5'd0);
    in_ready   = 1'b1;
    out_accept = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 9) in_ready = 1'b0;
      check("wrap_fd", frame_done, (k == 6 || k == 10));
      if (k == 6 || k == 10) check("wrap_zero_cnt", zero_cnt, 64);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("wrap_rst_fd", frame_done, 0);
      check("wrap_rst_zc", zero_cnt, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
